// File: rtl/bit_serial_alu_ctrl_if.sv
// Request/response handshake between a requester and the bit-serial ALU controller.
// The master drives requests and consumes results; the controller is the slave.
interface bit_serial_alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start_valid, op, a_in, b_in, out_ready,
        input  start_ready, out_valid, result, carry_out, overflow, zero
    );

    modport slave (
        input  start_valid, op, a_in, b_in, out_ready,
        output start_ready, out_valid, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Drives an external single-bit ALU slice one bit per clock, LSB first, holding the
// ripple carry between bits and returning the assembled WIDTH-bit result with flags.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bit_serial_alu_ctrl_if.slave  bus,
    output logic                  slice_a,
    output logic                  slice_b,
    output logic                  slice_ainvert,
    output logic                  slice_binvert,
    output logic                  slice_carryin,
    output logic [1:0]            slice_operation,
    input  logic                  slice_result,
    input  logic                  slice_carryout
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] r_q, r_d;          // upper partial result; bit 0 is never needed
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ainv_q, ainv_d;
    logic             binv_q, binv_d;
    logic [1:0]       sop_q, sop_d;
    logic             arith_q, arith_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] r_next;
    logic             running;

    assign running = (state_q == RUN);
    assign r_next  = {slice_result, r_q};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        r_d         = r_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        ainv_d      = ainv_q;
        binv_d      = binv_q;
        sop_d       = sop_q;
        arith_d     = arith_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_sh_d  = bus.a_in;
                    b_sh_d  = bus.b_in;
                    cnt_d   = '0;
                    c_d     = (bus.op == OP_SUB);
                    arith_d = (bus.op == OP_ADD) || (bus.op == OP_SUB);
                    ainv_d  = 1'b0;
                    binv_d  = 1'b0;
                    case (bus.op)
                        OP_AND:  sop_d = 2'b00;
                        OP_OR:   sop_d = 2'b01;
                        OP_ADD:  sop_d = 2'b10;
                        OP_SUB:  begin sop_d = 2'b10; binv_d = 1'b1; end
                        OP_NOR:  begin sop_d = 2'b00; ainv_d = 1'b1; binv_d = 1'b1; end
                        OP_NAND: begin sop_d = 2'b01; ainv_d = 1'b1; binv_d = 1'b1; end
                        default: sop_d = 2'b11;
                    endcase
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_d    = r_next[WIDTH-1:1];
                c_d    = slice_carryout;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Counter holds on the last bit so it never wraps inside an operation.
                    result_d    = r_next;
                    carry_out_d = arith_q & slice_carryout;
                    overflow_d  = arith_q & (c_q ^ slice_carryout);
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            r_q         <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            ainv_q      <= 1'b0;
            binv_q      <= 1'b0;
            sop_q       <= 2'b00;
            arith_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            r_q         <= r_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            ainv_q      <= ainv_d;
            binv_q      <= binv_d;
            sop_q       <= sop_d;
            arith_q     <= arith_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.carry_out   = carry_out_q;
    assign bus.overflow    = overflow_q;
    assign bus.zero        = (result_q == '0);

    // The slice sees only zeros outside RUN.
    assign slice_a         = running & a_sh_q[0];
    assign slice_b         = running & b_sh_q[0];
    assign slice_ainvert   = running & ainv_q;
    assign slice_binvert   = running & binv_q;
    assign slice_carryin   = running & c_q;
    assign slice_operation = running ? sop_q : 2'b00;
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl: models the ALU slice, predicts every output from
// whole-word arithmetic, and checks each cycle plus hand-computed directed vectors.
module tb_bit_serial_alu_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bit_serial_alu_ctrl_if #(.WIDTH(W)) bus ();

    logic       slice_a, slice_b, slice_ainvert, slice_binvert, slice_carryin;
    logic [1:0] slice_operation;
    logic       slice_result, slice_carryout;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .slice_a         (slice_a),
        .slice_b         (slice_b),
        .slice_ainvert   (slice_ainvert),
        .slice_binvert   (slice_binvert),
        .slice_carryin   (slice_carryin),
        .slice_operation (slice_operation),
        .slice_result    (slice_result),
        .slice_carryout  (slice_carryout)
    );

    // Single-bit ALU slice the controller drives.
    logic ae, be;
    always_comb begin
        ae             = slice_a ^ slice_ainvert;
        be             = slice_b ^ slice_binvert;
        slice_carryout = (ae & be) | (ae & slice_carryin) | (be & slice_carryin);
        case (slice_operation)
            2'b00:   slice_result = ae & be;
            2'b01:   slice_result = ae | be;
            2'b10:   slice_result = ae ^ be ^ slice_carryin;
            default: slice_result = 1'b0;
        endcase
    end

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } exp_t;

    function automatic exp_t golden(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'd3: begin
                s     = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'd4: e.res = ~(a | b);
            3'd5: e.res = ~(a & b);
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // Expected {ainvert, binvert, operation} presented to the slice while running.
    function automatic logic [3:0] slice_ctrl(input logic [2:0] op);
        case (op)
            3'd0:    return 4'b00_00;
            3'd1:    return 4'b00_01;
            3'd2:    return 4'b00_10;
            3'd3:    return 4'b01_10;
            3'd4:    return 4'b11_00;
            3'd5:    return 4'b11_01;
            default: return 4'b00_11;
        endcase
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 running, 2 result presented.
    int         m_phase = 0;
    int         m_bits  = 0;
    logic [2:0] m_op    = '0;
    exp_t       m_pend  = '0;
    exp_t       m_out   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_out   = '0;
        end else begin
            case (m_phase)
                0: if (bus.start_valid) begin
                    m_phase = 1;
                    m_bits  = 0;
                    m_op    = bus.op;
                    m_pend  = golden(bus.op, bus.a_in, bus.b_in);
                end
                1: begin
                    m_bits++;
                    if (m_bits == W) begin
                        m_phase = 2;
                        m_out   = m_pend;
                    end
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [3:0] ec;
        ec = (m_phase == 1) ? slice_ctrl(m_op) : 4'b0;
        check("start_ready", 32'(bus.start_ready), 32'(m_phase == 0));
        check("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
        check("result", 32'(bus.result), 32'(m_out.res));
        check("carry_out", 32'(bus.carry_out), 32'(m_out.c));
        check("overflow", 32'(bus.overflow), 32'(m_out.v));
        check("zero", 32'(bus.zero), 32'(m_out.res == '0));
        check("slice_ctrl", 32'({slice_ainvert, slice_binvert, slice_operation}), 32'(ec));
        if (m_phase != 1)
            check("slice_idle", 32'({slice_a, slice_b, slice_carryin}), 32'(0));
    end

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 3 * W) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input logic ev, input int hold);
        int edges;
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.op          = o;
        bus.a_in        = a;
        bus.b_in        = b;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        check("accepted", 32'(bus.start_ready), 32'(0));
        wait_valid(edges);
        check("latency", 32'(edges), 32'(W));
        check("lit_result", 32'(bus.result), 32'(er));
        check("lit_carry", 32'(bus.carry_out), 32'(ec));
        check("lit_overflow", 32'(bus.overflow), 32'(ev));
        check("lit_zero", 32'(bus.zero), 32'(er == '0));
        for (int i = 0; i < hold; i++) begin
            bus.start_valid = (i % 2 == 0);
            bus.a_in        = ~a;
            @(posedge clk); #1;
            check("hold_result", 32'(bus.result), 32'(er));
            check("hold_ready", 32'(bus.start_ready), 32'(0));
            check("hold_valid", 32'(bus.out_valid), 32'(1));
        end
        bus.start_valid = 1'b0;
        bus.out_ready   = 1'b1;
        @(posedge clk); #1;
        bus.out_ready   = 1'b0;
        check("back_idle", 32'(bus.start_ready), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int edges;
        bus.start_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.op          = '0;
        bus.a_in        = '0;
        bus.b_in        = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_ready", 32'(bus.start_ready), 32'(1));
        check("rst_zero", 32'(bus.zero), 32'(1));
        check("rst_valid", 32'(bus.out_valid), 32'(0));
        check("rst_result", 32'(bus.result), 32'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        run_op(3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
        run_op(3'd3, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 0);
        run_op(3'd3, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0);
        run_op(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 5);
        run_op(3'd1, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 0);
        run_op(3'd4, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 0);
        run_op(3'd5, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
        run_op(3'd6, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 0);

        // Back-to-back: release and request together in DONE, accept one edge later.
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.op = 3'd2; bus.a_in = 8'h03; bus.b_in = 8'h04;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        wait_valid(edges);
        check("b2b_first", 32'(bus.result), 32'(8'h07));
        bus.out_ready   = 1'b1;
        bus.start_valid = 1'b1;
        bus.a_in = 8'h10; bus.b_in = 8'h20;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("b2b_idle", 32'(bus.start_ready), 32'(1));
        check("b2b_novalid", 32'(bus.out_valid), 32'(0));
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        check("b2b_accept", 32'(bus.start_ready), 32'(0));
        wait_valid(edges);
        check("b2b_latency", 32'(edges), 32'(W));
        check("b2b_second", 32'(bus.result), 32'(8'h30));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset while the slice is working on bit 3.
        bus.start_valid = 1'b1;
        bus.op = 3'd2; bus.a_in = 8'h11; bus.b_in = 8'h22;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        check("mid_rst_ready", 32'(bus.start_ready), 32'(1));
        check("mid_rst_result", 32'(bus.result), 32'(0));
        check("mid_rst_zero", 32'(bus.zero), 32'(1));
        check("mid_rst_flags", 32'({bus.carry_out, bus.overflow}), 32'(0));
        check("mid_rst_slice", 32'({slice_operation, slice_carryin, slice_a, slice_b}), 32'(0));
        @(negedge clk);
        #2 rst = 1'b0;

        run_op(3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bit_serial_alu_ctrl.md
# bit_serial_alu_ctrl

Sequential controller that runs a full WIDTH-bit ALU operation through the team's single-bit ALU slice, one bit per clock, LSB first. It sits directly upstream of the slice. It drives the slice's operand, invert, carry-in and operation inputs, and consumes the slice's result and carry-out. It holds the ripple carry in a flip-flop between bits, assembles the WIDTH-bit result, and returns it with flags over a valid/ready handshake.

## Interface
- WIDTH, 8: operand and result width in bits; minimum 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  request is present.
- start_ready  output  1  controller can accept a request; high only in IDLE.
- op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 NAND, 110/111 reserved.
- a_in, b_in  input  WIDTH  operands; sampled on the accept edge.
- slice_a, slice_b  output  1  current operand bits driven to the slice.
- slice_ainvert, slice_binvert  output  1  invert controls driven to the slice.
- slice_carryin  output  1  carry into the current bit.
- slice_operation  output  2  slice function select: 00 AND, 01 OR, 10 ADD, 11 zero.
- slice_result, slice_carryout  input  1  combinational responses from the slice.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  assembled result.
- carry_out  output  1  final carry; 0 for logic ops.
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
- zero  output  1  high when result equals 0.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - start_ready = 1.
  - On start_valid & start_ready: latch a_in → a_sh and b_in → b_sh.
  - Latch the decoded controls: ainv, binv, sop.
  - Set the carry register c to 1 for SUB, otherwise 0.
  - Clear the bit counter and go to RUN.
- **Decode**
  - AND: 00, inv 0/0.
  - OR: 01, inv 0/0.
  - ADD: 10, inv 0/0.
  - SUB: 10, binv 1, initial carry 1.
  - NOR: 00, inv 1/1.
  - NAND: 01, inv 1/1.
  - Reserved: 11, inv 0/0.
- **RUN**, one bit per cycle
  - Slice drives: slice_a = a_sh[0], slice_b = b_sh[0], slice_carryin = c. Invert and operation outputs come from the latched controls.
  - Each edge:
    - a_sh and b_sh shift right by 1.
    - r <= {slice_result, r[WIDTH-1:1]}.
    - c <= slice_carryout.
    - The counter increments.
  - On the edge where counter = WIDTH-1:
    - carry_out <= slice_carryout, but only for ADD/SUB; otherwise 0.
    - overflow <= c ^ slice_carryout, but only for ADD/SUB; otherwise 0.
    - Go to DONE.
- **DONE**
  - out_valid = 1.
  - result, carry_out, overflow and zero are held stable.
  - On out_ready, go to IDLE.
  - start_valid is ignored.
- **Outside RUN**: all slice_* outputs are 0.
- **Flags**: zero = (result == 0), evaluated combinationally from the result register.
- **Arithmetic**
  - Modulo 2^WIDTH.
  - carry_out for SUB is the inverted borrow: 1 means no borrow.
- The counter is $clog2(WIDTH) bits wide and never wraps within an operation.

## Timing
- **Reset** is asynchronous: state goes to IDLE immediately. These are cleared to 0:
  - result, carry_out, overflow, out_valid;
  - all slice_* outputs;
  - the counter and c.
- **After reset**: start_ready = 1, zero = 1.
- **Latency**: with acceptance on edge 0, RUN covers cycles 1..WIDTH. out_valid rises after edge WIDTH.
- **Throughput**: one operation per WIDTH+2 cycles minimum (accept, WIDTH bits, handoff). There is no bypass from DONE to a new accept.
- **Reset mid-RUN or mid-DONE**: the operation is abandoned, no output is produced, and the next request is handled normally.
- **Output stability**: result and flags change only on the final RUN edge and on reset.
- **Back-to-back**: out_ready and start_valid both high in DONE gives DONE→IDLE. The accept happens on the following edge.

## Test plan
- ADD 0x7F + 0x01, WIDTH = 8 → result 0x80, carry_out 0, overflow 1, zero 0. out_valid asserts exactly 8 edges after the accept edge.
- SUB 0x05 − 0x07 → 0xFE, carry_out 0, overflow 0. SUB 0x80 − 0x01 → 0x7F, carry_out 1, overflow 1.
- Logic ops:
  - AND 0xF0 & 0x3C → 0x30.
  - OR 0xF0 | 0x0C → 0xFC.
  - NOR 0xF0, 0x0F → 0x00 with zero 1.
  - NAND 0xFF, 0xFF → 0x00.
  - carry_out and overflow are 0 in every case.
- Backpressure: hold out_ready low for 5 cycles in DONE while pulsing start_valid → result and flags stay constant, start_ready stays 0, and no new request is accepted.
- Assert rst during RUN at bit 3 → all outputs go to 0 without waiting for a clock edge and the state is IDLE. Then ADD 0xFF + 0x01 → 0x00, carry_out 1, overflow 0, zero 1.
- Reserved op 3'b110 with 0xAA, 0x55 → slice_operation is 11 throughout RUN; result 0x00, zero 1, carry_out 0, overflow 0.
